// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: shared definitions for the WISC pipeline control unit.
//   - 4-bit opcode values (ADD=0 ... HLT=15)
//   - write-back destination select encodings
//   - packed control word carried down the pipe
package pipe_ctrl_pkg;

    localparam logic [3:0] OP_ADD    = 4'd0;
    localparam logic [3:0] OP_SUB    = 4'd1;
    localparam logic [3:0] OP_XOR    = 4'd2;
    localparam logic [3:0] OP_RED    = 4'd3;
    localparam logic [3:0] OP_SLL    = 4'd4;
    localparam logic [3:0] OP_SRA    = 4'd5;
    localparam logic [3:0] OP_ROR    = 4'd6;
    localparam logic [3:0] OP_PADDSB = 4'd7;
    localparam logic [3:0] OP_LW     = 4'd8;
    localparam logic [3:0] OP_SW     = 4'd9;
    localparam logic [3:0] OP_LLB    = 4'd10;
    localparam logic [3:0] OP_LHB    = 4'd11;
    localparam logic [3:0] OP_B      = 4'd12;
    localparam logic [3:0] OP_BR     = 4'd13;
    localparam logic [3:0] OP_PCS    = 4'd14;
    localparam logic [3:0] OP_HLT    = 4'd15;

    typedef enum logic [1:0] {
        DST_ALU  = 2'b00,
        DST_MEM  = 2'b01,
        DST_BYTE = 2'b10,
        DST_PCS  = 2'b11
    } dst_sel_e;

    typedef struct packed {
        logic     wreg;
        logic     alu_imm;
        dst_sel_e dst_sel;
        logic     mem_en;
        logic     mem_wr;
        logic     is_hlt;
    } ctrl_t;

    localparam ctrl_t CTRL_NOP = '0;

endpackage

// File: rtl/pipe_ctrl_decode.sv
// pipe_ctrl_decode: combinational opcode decoder.
// Ports:
//   op     in   OP_W  opcode of the ID-stage instruction
//   ctrl   out  control word for that opcode
//   use_rs out  instruction reads the rs field
//   use_rt out  instruction reads the rt field
//   use_rd out  instruction reads the rd field (SW data, LLB/LHB merge)
module pipe_ctrl_decode
    import pipe_ctrl_pkg::*;
#(
    parameter int OP_W = 4
) (
    input  logic [OP_W-1:0] op,
    output ctrl_t           ctrl,
    output logic            use_rs,
    output logic            use_rt,
    output logic            use_rd
);

    always_comb begin
        ctrl   = CTRL_NOP;
        use_rs = 1'b0;
        use_rt = 1'b0;
        use_rd = 1'b0;
        case (op)
            OP_ADD, OP_SUB, OP_XOR, OP_RED, OP_PADDSB: begin
                ctrl.wreg = 1'b1;
                use_rs    = 1'b1;
                use_rt    = 1'b1;
            end
            OP_SLL, OP_SRA, OP_ROR: begin
                ctrl.wreg    = 1'b1;
                ctrl.alu_imm = 1'b1;
                use_rs       = 1'b1;
            end
            OP_LW: begin
                ctrl.wreg    = 1'b1;
                ctrl.alu_imm = 1'b1;
                ctrl.dst_sel = DST_MEM;
                ctrl.mem_en  = 1'b1;
                use_rs       = 1'b1;
            end
            OP_SW: begin
                ctrl.alu_imm = 1'b1;
                ctrl.mem_en  = 1'b1;
                ctrl.mem_wr  = 1'b1;
                use_rs       = 1'b1;
                use_rd       = 1'b1;
            end
            OP_LLB, OP_LHB: begin
                ctrl.wreg    = 1'b1;
                ctrl.dst_sel = DST_BYTE;
                use_rd       = 1'b1;
            end
            OP_PCS: begin
                ctrl.wreg    = 1'b1;
                ctrl.dst_sel = DST_PCS;
            end
            OP_BR: begin
                use_rs = 1'b1;
            end
            OP_HLT: begin
                ctrl.is_hlt = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: pipelined control unit for the 16-bit WISC core.
// Decodes the ID instruction, carries its control word through EX/MEM/WB,
// interlocks load-use hazards, kills the ID instruction on flush and
// latches a sticky halt once HLT reaches WB.
// Ports:
//   clk, rst_n          clock, async active-low reset
//   id_instr, id_valid  ID-stage instruction and its valid flag
//   flush               taken branch: ID instruction becomes a bubble
//   mem_stall           data memory busy: whole pipe holds
//   stall_if            hold PC and IF/ID this cycle
//   ex_*                EX-stage control (op, imm select, rd, write)
//   mem_*               MEM-stage control (write, enable, store, rd)
//   wb_*                WB-stage control (write, rd, result select)
//   halted              sticky, HLT has reached WB
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int OP_W      = 4,
    parameter int REG_W     = 4,
    parameter int INSTR_W   = 16,
    parameter bit HAZARD_EN = 1'b1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [INSTR_W-1:0] id_instr,
    input  logic               id_valid,
    input  logic               flush,
    input  logic               mem_stall,
    output logic               stall_if,
    output logic [OP_W-1:0]    ex_op,
    output logic               ex_alu_imm,
    output logic [REG_W-1:0]   ex_rd,
    output logic               ex_wreg,
    output logic               mem_wreg,
    output logic               wb_wreg,
    output logic               mem_en,
    output logic               mem_wr,
    output logic [REG_W-1:0]   mem_rd,
    output logic [REG_W-1:0]   wb_rd,
    output logic [1:0]         wb_dst_sel,
    output logic               halted
);

    logic [OP_W-1:0]  id_op;
    logic [REG_W-1:0] id_rd, id_rs, id_rt;

    assign id_op = id_instr[INSTR_W-1 -: OP_W];
    assign id_rd = id_instr[INSTR_W-OP_W-1 -: REG_W];
    assign id_rs = id_instr[INSTR_W-OP_W-REG_W-1 -: REG_W];
    assign id_rt = id_instr[INSTR_W-OP_W-2*REG_W-1 -: REG_W];

    ctrl_t dec_ctrl;
    logic  use_rs, use_rt, use_rd;

    pipe_ctrl_decode #(.OP_W(OP_W)) u_decode (
        .op     (id_op),
        .ctrl   (dec_ctrl),
        .use_rs (use_rs),
        .use_rt (use_rt),
        .use_rd (use_rd)
    );

    // EX stage keeps the full control word; later stages keep only what
    // they still need.
    ctrl_t            ex_ctrl;
    logic [OP_W-1:0]  ex_op_q;
    logic [REG_W-1:0] ex_rd_q;

    logic             mem_wreg_q, mem_en_q, mem_wr_q, mem_hlt_q;
    dst_sel_e         mem_dst_q;
    logic [REG_W-1:0] mem_rd_q;

    logic             wb_wreg_q;
    dst_sel_e         wb_dst_q;
    logic [REG_W-1:0] wb_rd_q;

    logic             hlt_seen;   // HLT accepted into EX; nothing follows it
    logic             halted_q;

    logic ex_is_load, src_match, load_use, accept;

    assign ex_is_load = ex_ctrl.mem_en & ~ex_ctrl.mem_wr;
    assign src_match  = (use_rs && (id_rs == ex_rd_q)) ||
                        (use_rt && (id_rt == ex_rd_q)) ||
                        (use_rd && (id_rd == ex_rd_q));
    assign load_use   = HAZARD_EN && id_valid && ex_is_load && src_match;
    assign accept     = id_valid && !flush && !load_use && !hlt_seen;

    // Flush overrides the load-use hold since the consumer is being killed.
    assign stall_if   = mem_stall | hlt_seen | (load_use & ~flush);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_ctrl    <= CTRL_NOP;
            ex_op_q    <= '0;
            ex_rd_q    <= '0;
            mem_wreg_q <= 1'b0;
            mem_en_q   <= 1'b0;
            mem_wr_q   <= 1'b0;
            mem_hlt_q  <= 1'b0;
            mem_dst_q  <= DST_ALU;
            mem_rd_q   <= '0;
            wb_wreg_q  <= 1'b0;
            wb_dst_q   <= DST_ALU;
            wb_rd_q    <= '0;
            hlt_seen   <= 1'b0;
            halted_q   <= 1'b0;
        end else if (!mem_stall) begin
            ex_ctrl    <= accept ? dec_ctrl : CTRL_NOP;
            ex_op_q    <= accept ? id_op : '0;
            ex_rd_q    <= accept ? id_rd : '0;

            mem_wreg_q <= ex_ctrl.wreg;
            mem_en_q   <= ex_ctrl.mem_en;
            mem_wr_q   <= ex_ctrl.mem_wr;
            mem_hlt_q  <= ex_ctrl.is_hlt;
            mem_dst_q  <= ex_ctrl.dst_sel;
            mem_rd_q   <= ex_rd_q;

            wb_wreg_q  <= mem_wreg_q;
            wb_dst_q   <= mem_dst_q;
            wb_rd_q    <= mem_rd_q;

            if (accept && dec_ctrl.is_hlt) begin
                hlt_seen <= 1'b1;
            end
            // Set on the same edge the HLT moves into WB.
            if (mem_hlt_q) begin
                halted_q <= 1'b1;
            end
        end
    end

    assign ex_op      = ex_op_q;
    assign ex_alu_imm = ex_ctrl.alu_imm;
    assign ex_rd      = ex_rd_q;
    assign ex_wreg    = ex_ctrl.wreg;
    assign mem_wreg   = mem_wreg_q;
    assign mem_en     = mem_en_q;
    assign mem_wr     = mem_wr_q;
    assign mem_rd     = mem_rd_q;
    assign wb_wreg    = wb_wreg_q;
    assign wb_rd      = wb_rd_q;
    assign wb_dst_sel = wb_dst_q;
    assign halted     = halted_q;

endmodule
